uart_tx_ctrl: RTL

Transmit-side frame sequencer for the UART. It accepts a byte over a valid/ready handshake and drives the TX baud generator's enable (`tx_baud_rate_reg_en`). It consumes that generator's one-cycle tick (`tx_baud_rate`) to shift out start, data, optional parity and stop bits on the serial line. It sits between the CPU-side TX register interface and the baud-rate generator, and is the sole owner of the generator's TX enable.

---
 rtl/uart_tx_ctrl_if.sv | 41 ++++
 rtl/uart_tx_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl_if.sv
// Handshake and baud-generator signals around the UART transmit frame sequencer.
// master: CPU-side register interface plus the baud generator; slave: uart_tx_ctrl.
interface uart_tx_ctrl_if #(
  parameter int unsigned DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 parity_odd;
  logic                 baud_tick;
  logic                 baud_en;
  logic                 tx_out;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output tx_data,
    output tx_valid,
    output parity_odd,
    output baud_tick,
    input  tx_ready,
    input  baud_en,
    input  tx_out,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  parity_odd,
    input  baud_tick,
    output tx_ready,
    output baud_en,
    output tx_out,
    output tx_busy,
    output tx_done
  );

endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, DATA_BITS data (LSB first), optional parity, stop bits.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_ctrl #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input logic           clock,
  input logic           reset,
  uart_tx_ctrl_if.slave bus
);

  localparam int unsigned CntW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_BITS - 1);
  localparam logic StopLast = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e               state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [CntW-1:0]      bit_cnt_q;
  logic                 stop_cnt_q;
  logic                 tx_out_q;
  logic                 baud_en_q;
  logic                 tx_busy_q;
  logic                 tx_done_q;

`ifdef UART_TX_PARITY_EN
  // Parity taken from the accepted byte, since the shift register is consumed during DATA.
  logic                 parity_q;
`else
  logic                 unused_parity_odd;
  assign unused_parity_odd = bus.parity_odd;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_out_q   <= 1'b1;
      baud_en_q  <= 1'b0;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      tx_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // baud_tick is ignored here, including one coincident with the accept edge.
          if (bus.tx_valid) begin
            shift_q   <= bus.tx_data;
            state_q   <= StStart;
            tx_out_q  <= 1'b0;
            baud_en_q <= 1'b1;
            tx_busy_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= (^bus.tx_data) ^ bus.parity_odd;
`endif
          end
        end
        StStart: begin
          if (bus.baud_tick) begin
            state_q   <= StData;
            tx_out_q  <= shift_q[0];
            bit_cnt_q <= '0;
          end
        end
        StData: begin
          if (bus.baud_tick) begin
            if (bit_cnt_q == LastBit) begin
`ifdef UART_TX_PARITY_EN
              state_q    <= StParity;
              tx_out_q   <= parity_q;
`else
              state_q    <= StStop;
              tx_out_q   <= 1'b1;
              stop_cnt_q <= 1'b0;
`endif
            end else begin
              shift_q   <= shift_q >> 1;
              tx_out_q  <= shift_q[1];
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (bus.baud_tick) begin
            state_q    <= StStop;
            tx_out_q   <= 1'b1;
            stop_cnt_q <= 1'b0;
          end
        end
`endif
        StStop: begin
          tx_out_q <= 1'b1;
          if (bus.baud_tick) begin
            if (stop_cnt_q == StopLast) begin
              state_q   <= StIdle;
              baud_en_q <= 1'b0;
              tx_busy_q <= 1'b0;
              tx_done_q <= 1'b1;
            end else begin
              stop_cnt_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          tx_out_q  <= 1'b1;
          baud_en_q <= 1'b0;
          tx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_ready = (state_q == StIdle);
  assign bus.baud_en  = baud_en_q;
  assign bus.tx_out   = tx_out_q;
  assign bus.tx_busy  = tx_busy_q;
  assign bus.tx_done  = tx_done_q;

  // The generator enable must track the frame exactly; done only ever fires on return to idle.
  assert property (@(posedge clock) disable iff (reset) baud_en_q == tx_busy_q);
  assert property (@(posedge clock) disable iff (reset) tx_done_q |-> (state_q == StIdle));

endmodule
